// File: rtl/parity_frame_rx.sv
// parity_frame_rx: start/data/parity/stop serial receiver with parity and framing check; optional err_cnt_o via PARITY_FRAME_RX_ERR_CNT_EN
module parity_frame_rx #(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              parity_err_o,
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
  output logic              frame_err_o,
  output logic [7:0]        err_cnt_o
`else
  output logic              frame_err_o
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic PODD = (PARITY_ODD != 0);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t state;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bidx;
  logic [DATA_W-1:0] sh;
  logic p, rx_s, last, mid, perr_n;
  assign rx_s = sync[1];
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign mid = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign perr_n = (^sh ^ p) != PODD;
  // two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], rx_i};
  // frame FSM with registered word, status and pulse outputs
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bidx <= '0;
      sh <= '0;
      p <= 1'b0;
      data_o <= '0;
      valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
      err_cnt_o <= '0;
`endif
    end else begin
      valid_o <= 1'b0;
      cnt <= last ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START:
          if (mid) begin
            cnt <= '0;
            bidx <= '0;
            state <= rx_s ? IDLE : DATA;
          end
        DATA:
          if (last) begin
            sh <= (sh >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
            bidx <= bidx + 1'b1;
            if (bidx == BW'(DATA_W - 1)) state <= PARITY;
          end
        PARITY:
          if (last) begin
            p <= rx_s;
            state <= STOP;
          end
        STOP:
          if (last) begin
            valid_o <= 1'b1;
            data_o <= sh;
            parity_err_o <= perr_n;
            frame_err_o <= ~rx_s;
            state <= rx_s ? IDLE : BRK;
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
            if ((perr_n | ~rx_s) && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 1'b1;
`endif
          end
        BRK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
